trigger_pulse_sequencer: RTL and testbench
==========================================

# trigger_pulse_sequencer

Sequences timed output pulses relative to a target trigger. After being armed, the block waits for a rising edge on the synchronized trigger from the ESP differential input. It then counts a programmable delay, drives a programmable-width pulse, and repeats for a programmed number of shots. It sits in the 200 MHz passthrough clock domain between the trigger synchronizer and the pulse output pin / LED status.

## Interface
- `DELAY_W`, 16: width of delay config/counter.
- `WIDTH_W`, 8: width of pulse-width config/counter.
- `SHOT_W`, 8: width of shot count config/counter.
- `HOLDOFF_CYC`, 16: fixed holdoff cycles after each pulse (legal ≥1).
- `sysclk`  in  1  200 MHz clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `arm`  in  1  start request; accepted only in IDLE.
- `abort`  in  1  return to IDLE from any state.
- `trig_in`  in  1  trigger level, already synchronized to `sysclk`.
- `delay_cfg`  in  DELAY_W  trigger-to-pulse delay, cycles.
- `width_cfg`  in  WIDTH_W  pulse width, cycles (0 treated as 1).
- `shots_cfg`  in  SHOT_W  pulses per arm (0 treated as 1).
- `pulse_out`  out  1  registered pulse output.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle strobe on normal completion.
- `shot_count`  out  SHOT_W  pulses completed since last accepted arm.
- `trig_missed`  out  1  sticky; a trigger edge arrived while not in WAIT_TRIG and busy.
- `state_out`  out  3  IDLE=0, WAIT_TRIG=1, DELAY=2, PULSE=3, HOLDOFF=4.

## Operation
- **Reset** (`rst_n`=0 at a clock edge): state IDLE.
  - `pulse_out`, `busy`, `done`, `trig_missed`, `shot_count` all 0.
  - `trig_prev` is cleared to 0.
- **Edge detect:** edge = `trig_in` & ~`trig_prev`. `trig_prev` updates every cycle in every state.
- **IDLE + `arm`:**
  - Latch `delay_cfg`, `width_cfg`, `shots_cfg`; config changes are ignored until the next arm.
  - Clear `shot_count` and `trig_missed`.
  - Go to WAIT_TRIG.
- **WAIT_TRIG + edge:** go to PULSE if latched delay = 0, else go to DELAY.
- **DELAY:** stays for exactly delay cycles, then goes to PULSE.
- **PULSE:** `pulse_out`=1 for exactly W cycles. On exit, `shot_count`++ and go to HOLDOFF.
- **HOLDOFF:** stays exactly HOLDOFF_CYC cycles. Then:
  - if `shot_count` == shots, go to IDLE with `done`=1 that cycle;
  - otherwise go to WAIT_TRIG.
- An edge in DELAY, PULSE or HOLDOFF is ignored and sets `trig_missed`. Edges in IDLE are ignored and have no effect.
- **`abort`** (any state): IDLE next cycle.
  - `pulse_out` low next cycle; no `done`.
  - `shot_count` and `trig_missed` hold their values.
  - `abort` beats `arm` in the same cycle.
- `arm` outside IDLE is ignored.
- `shot_count` saturates at 2^SHOT_W−1 (unreachable with legal config).

## Timing
- All outputs are registered.
- **Pulse window:** if the edge is sampled at rising edge T, `pulse_out` is high on cycles T+1+D … T+D+W (D = latched delay, W = effective width).
- **After the pulse:** `shot_count` increments on cycle T+D+W+1, the first HOLDOFF cycle.
- **Final shot:** `done` and the IDLE state appear on cycle T+D+W+1+HOLDOFF_CYC. `busy` falls that same cycle.
- **Next shot:** WAIT_TRIG is entered on cycle T+D+W+1+HOLDOFF_CYC. An edge on that cycle is accepted.
- **Arm:** `arm` sampled at cycle A gives state WAIT_TRIG and `busy`=1 at A+1. An edge sampled at A+1 is accepted.
- **Level-high trigger at arm time:** if `trig_in` is already high when armed, no edge occurs until it falls and rises again.
- **Reset mid-pulse:** `pulse_out` is 0 on the cycle after `rst_n` is sampled low.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `trig_in` toggling → all outputs 0, `state_out`=0.
- **Single shot:** D=5, W=3, shots=1, HOLDOFF_CYC=16.
  - Edge at T → `pulse_out` high T+6..T+8.
  - `shot_count`=1 at T+9.
  - `done` single cycle at T+25; `busy` low at T+25.
- **Boundary config:** D=0, W=0, shots=0 → exactly one pulse, 1 cycle wide, at T+1; `done` at T+18.
- **Multi-shot with missed triggers:** shots=3, D=2, W=2.
  - Edges spaced 40 cycles apart, plus one extra edge inside DELAY → three pulses, `shot_count` 1→2→3, `trig_missed`=1, `done` once.
  - Re-arm → `trig_missed`=0, `shot_count`=0.
- **Abort:** assert `abort` during the 2nd cycle of a W=10 pulse → `pulse_out` low next cycle, `state_out`=0, no `done`, `shot_count` unchanged.
  - Assert `arm` and `abort` together in IDLE → stays IDLE.
- **Config isolation:** change `delay_cfg` from 5 to 100 while in WAIT_TRIG → pulse still at T+6.
  - A trigger held high at arm produces no pulse until it falls and rises again.

Source files
------------

// File: rtl/trigger_pulse_sequencer.sv
// Trigger-relative pulse sequencer: arm, wait for a trigger edge, delay, pulse, holdoff, repeat per shot.
// Every output is registered, so it changes in the same cycle as the state it reflects.
module trigger_pulse_sequencer #(
  parameter int DELAY_W     = 16,
  parameter int WIDTH_W     = 8,
  parameter int SHOT_W      = 8,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig_in,
  input  logic [DELAY_W-1:0] delay_cfg,
  input  logic [WIDTH_W-1:0] width_cfg,
  input  logic [SHOT_W-1:0]  shots_cfg,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic [SHOT_W-1:0]  shot_count,
  output logic               trig_missed,
  output logic [2:0]         state_out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TRIG = 3'd1,
    S_DELAY     = 3'd2,
    S_PULSE     = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_e;

  // One down-counter serves delay, pulse width and holdoff; size it for the widest.
  localparam int HO_W  = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam int DW_W  = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
  localparam int CNT_W = (DW_W > HO_W) ? DW_W : HO_W;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLDOFF_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [WIDTH_W-1:0]  width_q, width_d;
  logic [SHOT_W-1:0]   shots_q, shots_d;
  logic [SHOT_W-1:0]   shot_count_q, shot_count_d;
  logic                trig_missed_q, trig_missed_d;
  logic                trig_prev_q;
  logic                pulse_q;
  logic                busy_q;
  logic                done_q, done_d;

  logic                trig_edge;
  logic [CNT_W-1:0]    width_m1;
  logic [CNT_W-1:0]    delay_m1;
  logic [SHOT_W-1:0]   shots_eff;

  assign trig_edge = trig_in & ~trig_prev_q;
  // A zero width or shot count behaves as one.
  assign width_m1  = (width_q == '0) ? '0 : CNT_W'(width_q - WIDTH_W'(1));
  assign delay_m1  = CNT_W'(delay_q - DELAY_W'(1));
  assign shots_eff = (shots_q == '0) ? SHOT_W'(1) : shots_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    delay_d       = delay_q;
    width_d       = width_q;
    shots_d       = shots_q;
    shot_count_d  = shot_count_q;
    trig_missed_d = trig_missed_q;
    done_d        = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            delay_d       = delay_cfg;
            width_d       = width_cfg;
            shots_d       = shots_cfg;
            shot_count_d  = '0;
            trig_missed_d = 1'b0;
            state_d       = S_WAIT_TRIG;
          end
        end

        S_WAIT_TRIG: begin
          if (trig_edge) begin
            if (delay_q == '0) begin
              state_d = S_PULSE;
              cnt_d   = width_m1;
            end else begin
              state_d = S_DELAY;
              cnt_d   = delay_m1;
            end
          end
        end

        S_DELAY: begin
          if (trig_edge) trig_missed_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_PULSE;
            cnt_d   = width_m1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_PULSE: begin
          if (trig_edge) trig_missed_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_HOLDOFF;
            cnt_d   = HOLD_M1;
            if (shot_count_q != '1) shot_count_d = shot_count_q + SHOT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_HOLDOFF: begin
          if (trig_edge) trig_missed_d = 1'b1;
          if (cnt_q == '0) begin
            if (shot_count_q == shots_eff) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_WAIT_TRIG;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      delay_q       <= '0;
      width_q       <= '0;
      shots_q       <= '0;
      shot_count_q  <= '0;
      trig_missed_q <= 1'b0;
      trig_prev_q   <= 1'b0;
      pulse_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      delay_q       <= delay_d;
      width_q       <= width_d;
      shots_q       <= shots_d;
      shot_count_q  <= shot_count_d;
      trig_missed_q <= trig_missed_d;
      trig_prev_q   <= trig_in;
      // Decoding from the next state keeps these flops aligned with state_q.
      pulse_q       <= (state_d == S_PULSE);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= done_d;
    end
  end

  assign pulse_out   = pulse_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign shot_count  = shot_count_q;
  assign trig_missed = trig_missed_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_trigger_pulse_sequencer.sv
// Directed bench for trigger_pulse_sequencer with hand-computed cycle expectations.
// Sample index k=1 is the cycle right after the trigger edge is sampled (cycle T+1).
module tb_trigger_pulse_sequencer;
  localparam int DELAY_W     = 16;
  localparam int WIDTH_W     = 8;
  localparam int SHOT_W      = 8;
  localparam int HOLDOFF_CYC = 16;
  localparam int NS          = 64;

  logic               sysclk = 1'b0;
  logic               rst_n, arm, abort, trig_in;
  logic [DELAY_W-1:0] delay_cfg;
  logic [WIDTH_W-1:0] width_cfg;
  logic [SHOT_W-1:0]  shots_cfg;
  logic               pulse_out, busy, done, trig_missed;
  logic [SHOT_W-1:0]  shot_count;
  logic [2:0]         state_out;

  int vectors     = 0;
  int miscompares = 0;

  logic              p_a  [1:NS];
  logic              d_a  [1:NS];
  logic              b_a  [1:NS];
  logic              tm_a [1:NS];
  logic [SHOT_W-1:0] sc_a [1:NS];
  logic [2:0]        st_a [1:NS];

  always #5 sysclk = ~sysclk;

  trigger_pulse_sequencer #(
    .DELAY_W(DELAY_W), .WIDTH_W(WIDTH_W), .SHOT_W(SHOT_W), .HOLDOFF_CYC(HOLDOFF_CYC)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_in(trig_in),
    .delay_cfg(delay_cfg), .width_cfg(width_cfg), .shots_cfg(shots_cfg),
    .pulse_out(pulse_out), .busy(busy), .done(done), .shot_count(shot_count),
    .trig_missed(trig_missed), .state_out(state_out)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_arm(input int d, input int w, input int s);
    delay_cfg = DELAY_W'(d);
    width_cfg = WIDTH_W'(w);
    shots_cfg = SHOT_W'(s);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic fire();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  // Records n cycles of outputs; with extra set, a stray edge is sampled at T+2.
  task automatic observe(input int n, input bit extra);
    for (int k = 1; k <= n; k++) begin
      p_a[k]  = pulse_out;
      d_a[k]  = done;
      b_a[k]  = busy;
      tm_a[k] = trig_missed;
      sc_a[k] = shot_count;
      st_a[k] = state_out;
      trig_in = extra && (k == 2);
      tick();
    end
    trig_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trig_in = ~trig_in;
      tick();
    end
    vectors++;
    if ({pulse_out, busy, done, trig_missed} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000", {pulse_out, busy, done, trig_missed});
    end
    vectors++;
    if (shot_count !== '0 || state_out !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_count_state got sc=%0d st=%0d want 0/0", shot_count, state_out);
    end
    trig_in = 1'b0;
    rst_n   = 1'b1;
    tick();
  endtask

  task automatic test_single_shot();
    do_arm(5, 3, 1);
    vectors++;
    if (state_out !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL arm_wait got st=%0d busy=%b want 1/1", state_out, busy);
    end
    fire();
    observe(30, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      vectors++;
      if (p_a[k] !== (k >= 6 && k <= 8) || d_a[k] !== (k == 25) || b_a[k] !== (k < 25)) begin
        miscompares++;
        $display("FAIL single_pulse_done_busy k=%0d got p=%b d=%b b=%b", k, p_a[k], d_a[k], b_a[k]);
      end
      vectors++;
      if (sc_a[k] !== ((k >= 9) ? SHOT_W'(1) : SHOT_W'(0))) begin
        miscompares++;
        $display("FAIL single_shot_count k=%0d got %0d want %0d", k, sc_a[k], (k >= 9) ? 1 : 0);
      end
    end
    vectors++;
    if (st_a[25] !== 3'd0 || st_a[24] !== 3'd4) begin
      miscompares++;
      $display("FAIL single_state got k24=%0d k25=%0d want 4/0", st_a[24], st_a[25]);
    end
  endtask

  task automatic test_boundary_config();
    do_arm(0, 0, 0);
    fire();
    observe(30, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      vectors++;
      if (p_a[k] !== (k == 1) || d_a[k] !== (k == 18)) begin
        miscompares++;
        $display("FAIL boundary k=%0d got p=%b d=%b want p=%b d=%b", k, p_a[k], d_a[k], k == 1, k == 18);
      end
    end
    vectors++;
    if (sc_a[2] !== SHOT_W'(1) || st_a[18] !== 3'd0) begin
      miscompares++;
      $display("FAIL boundary_end got sc=%0d st=%0d want 1/0", sc_a[2], st_a[18]);
    end
  endtask

  task automatic test_multi_shot_missed();
    int done_seen;
    done_seen = 0;
    do_arm(2, 2, 3);
    for (int s = 1; s <= 3; s++) begin
      fire();
      observe(40, s == 1);
      for (int k = 1; k <= 40; k++) begin
        if (d_a[k] === 1'b1) done_seen++;
        vectors++;
        if (p_a[k] !== (k == 3 || k == 4)) begin
          miscompares++;
          $display("FAIL multi_pulse shot=%0d k=%0d got %b want %b", s, k, p_a[k], k == 3 || k == 4);
        end
        vectors++;
        if (sc_a[k] !== SHOT_W'((k >= 5) ? s : s - 1)) begin
          miscompares++;
          $display("FAIL multi_count shot=%0d k=%0d got %0d want %0d", s, k, sc_a[k], (k >= 5) ? s : s - 1);
        end
      end
      vectors++;
      if (st_a[21] !== ((s == 3) ? 3'd0 : 3'd1) || d_a[21] !== (s == 3)) begin
        miscompares++;
        $display("FAIL multi_end shot=%0d got st=%0d d=%b", s, st_a[21], d_a[21]);
      end
      if (s == 1) begin
        vectors++;
        if (tm_a[2] !== 1'b0 || tm_a[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL multi_missed_set got k2=%b k3=%b want 0/1", tm_a[2], tm_a[3]);
        end
      end
    end
    vectors++;
    if (tm_a[40] !== 1'b1 || done_seen != 1) begin
      miscompares++;
      $display("FAIL multi_final got missed=%b done_count=%0d want 1/1", tm_a[40], done_seen);
    end
    do_arm(0, 10, 2);
    vectors++;
    if (trig_missed !== 1'b0 || shot_count !== '0 || state_out !== 3'd1) begin
      miscompares++;
      $display("FAIL rearm_clear got missed=%b sc=%0d st=%0d want 0/0/1", trig_missed, shot_count, state_out);
    end
  endtask

  task automatic test_abort();
    // Armed with D=0, W=10, shots=2 by the previous task; the first shot runs to completion.
    fire();
    observe(30, 1'b0);
    vectors++;
    if (p_a[1] !== 1'b1 || p_a[10] !== 1'b1 || p_a[11] !== 1'b0 || sc_a[11] !== SHOT_W'(1) || st_a[27] !== 3'd1) begin
      miscompares++;
      $display("FAIL abort_first_shot got p1=%b p10=%b p11=%b sc=%0d st=%0d", p_a[1], p_a[10], p_a[11], sc_a[11], st_a[27]);
    end
    fire();
    vectors++;
    if (pulse_out !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pulse1 got %b want 1", pulse_out);
    end
    tick();
    vectors++;
    if (pulse_out !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pulse2 got %b want 1", pulse_out);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (pulse_out !== 1'b0 || state_out !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || shot_count !== SHOT_W'(1)) begin
      miscompares++;
      $display("FAIL abort_exit got p=%b st=%0d b=%b d=%b sc=%0d want 0/0/0/0/1", pulse_out, state_out, busy, done, shot_count);
    end
    observe(20, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      vectors++;
      if (p_a[k] !== 1'b0 || d_a[k] !== 1'b0 || st_a[k] !== 3'd0 || sc_a[k] !== SHOT_W'(1)) begin
        miscompares++;
        $display("FAIL abort_idle k=%0d got p=%b d=%b st=%0d sc=%0d", k, p_a[k], d_a[k], st_a[k], sc_a[k]);
      end
    end
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    vectors++;
    if (state_out !== 3'd0 || busy !== 1'b0 || shot_count !== SHOT_W'(1)) begin
      miscompares++;
      $display("FAIL arm_abort got st=%0d busy=%b sc=%0d want 0/0/1", state_out, busy, shot_count);
    end
  endtask

  task automatic test_config_isolation();
    do_arm(5, 3, 1);
    delay_cfg = DELAY_W'(100);
    tick();
    fire();
    observe(30, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      vectors++;
      if (p_a[k] !== (k >= 6 && k <= 8) || d_a[k] !== (k == 25)) begin
        miscompares++;
        $display("FAIL cfg_isolation k=%0d got p=%b d=%b", k, p_a[k], d_a[k]);
      end
    end
  endtask

  task automatic test_level_high_at_arm();
    delay_cfg = DELAY_W'(5);
    trig_in   = 1'b1;
    tick();
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (pulse_out !== 1'b0 || state_out !== 3'd1) begin
        miscompares++;
        $display("FAIL level_high_wait i=%0d got p=%b st=%0d want 0/1", i, pulse_out, state_out);
      end
    end
    trig_in = 1'b0;
    tick();
    fire();
    observe(30, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      vectors++;
      if (p_a[k] !== (k >= 6 && k <= 8) || d_a[k] !== (k == 25)) begin
        miscompares++;
        $display("FAIL level_high_pulse k=%0d got p=%b d=%b", k, p_a[k], d_a[k]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    arm       = 1'b0;
    abort     = 1'b0;
    trig_in   = 1'b0;
    delay_cfg = '0;
    width_cfg = '0;
    shots_cfg = '0;
    test_reset();
    test_single_shot();
    test_boundary_config();
    test_multi_shot_missed();
    test_abort();
    test_config_isolation();
    test_level_high_at_arm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
